// File: rtl/s1_bram_writer.sv
// Stage-1 result writer: streams 192 words into the feature BRAM as {cha,row,col}, pulses data_done, then holds off input until stage 2 is done.
// Optional S1W_RELU_EN clamps negative words to zero before the write.
module s1_bram_writer #(
  parameter int WIDTH           = 17,
  parameter int HANDOFF_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             s2_busy,
  output logic             bram_we,
  output logic [7:0]       bram_addr,
  output logic [WIDTH-1:0] bram_din,
  output logic             data_done,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, HANDOFF} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cha;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [7:0]  wcnt;
  logic [7:0]  tcnt;
  logic        seen_busy;
  logic        accept;
  logic        last_word;
  logic [WIDTH-1:0] wr_data;

  assign last_word = (wcnt == 8'd191);
  assign busy      = (state != IDLE);

`ifdef S1W_RELU_EN
  assign wr_data = in_data[WIDTH-1] ? '0 : in_data;
`else
  assign wr_data = in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, WRITE: begin
        in_ready = ~reset;
        accept   = in_valid & ~reset;
        if (accept) begin
          if (last_word)    state_nxt = DONE;
          else if (in_last) state_nxt = IDLE;
          else              state_nxt = WRITE;
        end
      end
      DONE: state_nxt = HANDOFF;
      HANDOFF: begin
        // Without a busy sighting, give up after the timeout so a missing stage 2 cannot wedge us.
        if (seen_busy && !s2_busy)
          state_nxt = IDLE;
        else if (!seen_busy && !s2_busy && tcnt == 8'(HANDOFF_TIMEOUT - 1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      data_done <= 1'b0;
      frame_err <= 1'b0;
      cha       <= '0;
      row       <= '0;
      col       <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      seen_busy <= 1'b0;
    end else begin
      bram_we   <= accept;
      frame_err <= accept & ((in_last & ~last_word) | (last_word & ~in_last));
      data_done <= (state == DONE);

      if (accept) begin
        bram_addr <= {cha, row, col};
        bram_din  <= wr_data;
        if (last_word || in_last) begin
          cha  <= '0;
          row  <= '0;
          col  <= '0;
          wcnt <= '0;
        end else begin
          wcnt <= wcnt + 8'd1;
          if (cha == 2'd2) begin
            cha <= '0;
            if (col == 3'd7) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end else begin
            cha <= cha + 2'd1;
          end
        end
      end

      if (state == HANDOFF) begin
        tcnt <= tcnt + 8'd1;
        if (s2_busy) seen_busy <= 1'b1;
      end else begin
        tcnt      <= '0;
        seen_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s1_bram_writer.sv
// Directed bench for s1_bram_writer: address layout, frame-length errors, stage-2 handoff, reset abort, ReLU option.
module tb_s1_bram_writer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_last, s2_busy;
  logic        bram_we, data_done, busy, frame_err;
  logic [16:0] in_data, bram_din;
  logic [7:0]  bram_addr;
  logic [7:0]  addr_log [192];
  int total = 0;
  int bad   = 0;

`ifdef S1W_RELU_EN
  localparam logic [16:0] NEG_EXP = 17'h00000;
`else
  localparam logic [16:0] NEG_EXP = 17'h1FFFB;
`endif

  s1_bram_writer #(.WIDTH(17), .HANDOFF_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .s2_busy(s2_busy),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .data_done(data_done), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] exp_addr(input int k);
    int p;
    p = k / 3;
    return {2'(k % 3), 3'(p / 8), 3'(p % 8)};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; s2_busy = 1'b0;
    cyc; cyc;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++;
    if ({bram_we, bram_addr, bram_din, data_done, busy, frame_err} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs we=%b addr=%h din=%h done=%b busy=%b err=%b want all 0",
               bram_we, bram_addr, bram_din, data_done, busy, frame_err);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  // Streams one 192-word frame at full rate; returns in the data_done cycle.
  task automatic run_frame(input string tag, input bit with_last, input logic [16:0] base);
    for (int k = 0; k < 192; k++) begin
      in_valid = 1'b1;
      in_data  = base + 17'(k);
      in_last  = with_last && (k == 191);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL %s ready k=%0d got=%b want=1", tag, k, in_ready); end
      cyc;
      total++;
      if (bram_we !== 1'b1 || bram_addr !== exp_addr(k) || bram_din !== base + 17'(k)) begin
        bad++;
        $display("FAIL %s write k=%0d we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                 tag, k, bram_we, bram_addr, bram_din, exp_addr(k), base + 17'(k));
      end
      addr_log[k] = bram_addr;
      total++;
      if (frame_err !== (k == 191 && !with_last)) begin
        bad++; $display("FAIL %s frame_err k=%0d got=%b want=%b", tag, k, frame_err, (k == 191 && !with_last));
      end
      total++;
      if (data_done !== 1'b0) begin bad++; $display("FAIL %s early_done k=%0d got=%b want=0", tag, k, data_done); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL %s done_state_ready got=%b want=0", tag, in_ready); end
    cyc;
    total++;
    if (data_done !== 1'b1 || bram_we !== 1'b0) begin
      bad++; $display("FAIL %s data_done done=%b we=%b want done=1 we=0", tag, data_done, bram_we);
    end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL %s err_at_done got=%b want=0", tag, frame_err); end
  endtask

  task automatic test_full_frame;
    run_frame("full", 1'b1, 17'h0);
    total++;
    if (addr_log[0] !== 8'h00 || addr_log[1] !== 8'h40 || addr_log[2] !== 8'h80 ||
        addr_log[3] !== 8'h01 || addr_log[191] !== 8'hBF) begin
      bad++;
      $display("FAIL full_addr_points got=%h %h %h %h %h want=00 40 80 01 bf",
               addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[191]);
    end
    cyc; cyc;
    s2_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL handoff_hold i=%0d ready=%b busy=%b want ready=0 busy=1", i, in_ready, busy);
      end
      cyc;
    end
    s2_busy = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL handoff_fall_cycle ready=%b want=0", in_ready); end
    cyc;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL handoff_release ready=%b busy=%b want ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_short_frame;
    for (int k = 0; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data  = 17'd100 + 17'(k);
      in_last  = (k == 10);
      cyc;
      total++;
      if (bram_we !== 1'b1 || bram_addr !== exp_addr(k) || bram_din !== 17'd100 + 17'(k) ||
          frame_err !== (k == 10)) begin
        bad++;
        $display("FAIL short write k=%0d we=%b addr=%h din=%h err=%b want we=1 addr=%h din=%h err=%b",
                 k, bram_we, bram_addr, bram_din, frame_err, exp_addr(k), 17'd100 + 17'(k), (k == 10));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc;
      total++;
      if (data_done !== 1'b0 || in_ready !== 1'b1 || bram_we !== 1'b0) begin
        bad++; $display("FAIL short_idle i=%0d done=%b ready=%b we=%b want 0 1 0", i, data_done, in_ready, bram_we);
      end
    end
    in_valid = 1'b1; in_data = 17'd7;
    cyc;
    total++;
    if (bram_we !== 1'b1 || bram_addr !== 8'h00 || bram_din !== 17'd7 || frame_err !== 1'b0) begin
      bad++; $display("FAIL short_restart we=%b addr=%h din=%h err=%b want 1 00 00007 0", bram_we, bram_addr, bram_din, frame_err);
    end
    in_data = 17'd8; in_last = 1'b1;
    cyc;
    total++;
    if (bram_addr !== 8'h40 || frame_err !== 1'b1) begin
      bad++; $display("FAIL short_second addr=%h err=%b want 40 1", bram_addr, frame_err);
    end
    in_valid = 1'b0; in_last = 1'b0;
    cyc;
  endtask

  task automatic test_timeout;
    run_frame("timeout", 1'b0, 17'h100);
    s2_busy = 1'b0;
    cyc; cyc; cyc;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_early ready=%b busy=%b want 0 1", in_ready, busy);
    end
    cyc;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_release ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_midframe;
    int k;
    k = 0;
    for (int it = 0; it < 3000 && k < 100; it++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 17'(k);
      in_last  = 1'b0;
      cyc;
      total++;
      if (in_valid) begin
        if (bram_we !== 1'b1 || bram_addr !== exp_addr(k)) begin
          bad++; $display("FAIL gaps write k=%0d we=%b addr=%h want 1 %h", k, bram_we, bram_addr, exp_addr(k));
        end
        k++;
      end else if (bram_we !== 1'b0) begin
        bad++; $display("FAIL gaps idle_we k=%0d got=%b want=0", k, bram_we);
      end
    end
    total++;
    if (k < 100) begin bad++; $display("FAIL gaps_budget words=%0d want=100", k); end
    reset = 1'b1; in_valid = 1'b1; in_data = 17'd100;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b want=0", in_ready); end
    cyc;
    total++;
    if ({bram_we, bram_addr, bram_din, data_done, busy, frame_err} !== 30'd0) begin
      bad++;
      $display("FAIL midreset_outputs we=%b addr=%h din=%h done=%b busy=%b err=%b want all 0",
               bram_we, bram_addr, bram_din, data_done, busy, frame_err);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    run_frame("after_reset", 1'b1, 17'h0AB);
    repeat (4) cyc;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL after_reset_release ready=%b want=1", in_ready); end
  endtask

  task automatic test_relu;
    in_valid = 1'b1; in_data = 17'h1FFFB; in_last = 1'b1;
    cyc;
    total++;
    if (bram_we !== 1'b1 || bram_addr !== 8'h00 || bram_din !== NEG_EXP || frame_err !== 1'b1) begin
      bad++; $display("FAIL relu_neg we=%b addr=%h din=%h err=%b want 1 00 %h 1", bram_we, bram_addr, bram_din, frame_err, NEG_EXP);
    end
    in_data = 17'd5;
    cyc;
    total++;
    if (bram_addr !== 8'h00 || bram_din !== 17'd5) begin
      bad++; $display("FAIL relu_pos addr=%h din=%h want 00 00005", bram_addr, bram_din);
    end
    in_valid = 1'b0; in_last = 1'b0;
    cyc;
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_short_frame;
    test_timeout;
    test_reset_midframe;
    test_relu;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
